i2c_cfg_seq: RTL and testbench
==============================

I2C_CFG_SEQ -- requirements
Module: i2c_cfg_seq

Interface
REQ-001 SHALL have parameter REG_NUM, default 29: table entries executed per sequence, range 1..2**IDX_W.
REQ-002 SHALL have parameter IDX_W, default 6: table index width.
REQ-003 SHALL have parameter REG_AW, default 8: register address width, 8 or 16.
REQ-004 SHALL have parameter REG_DW, default 8: register data width, 8 or 16.
REQ-005 SHALL have parameter PWRUP_CYC, default 255: cycles from reset release to the first table fetch.
REQ-006 SHALL have parameter DLY_UNIT, default 1000: cycles per delay tick.
REQ-007 SHALL have parameter MAX_RETRY, default 3: attempts per entry before error.
REQ-008 SHALL define TW = 1+REG_AW+REG_DW with table word = {dly_flag, addr, data}.
REQ-009 SHALL have ports: clk in 1, system clock; rst_n in 1, reset.
REQ-010 SHALL have ports: cfg_start in 1, restart pulse; tbl_idx out IDX_W, ROM address; tbl_word in TW, ROM data with 1-cycle latency.
REQ-011 SHALL have ports: i2c_exec out 1, transfer start pulse; i2c_rh_wl out 1, 1=read; i2c_addr out REG_AW; i2c_wdata out REG_DW; i2c_done in 1, transfer-complete pulse; i2c_ack in 1, 1=slave NACK; i2c_rdata in REG_DW.
REQ-012 SHALL have ports: cfg_busy out 1; cfg_done out 1, level; cfg_err out 1, level; err_idx out IDX_W, failing entry.
REQ-013 SHALL use reset rst_n, asynchronous, active-low, and clock clk.

Function
REQ-014 SHALL implement states PWRUP, FETCH, WRITE, WAIT_W, READ, WAIT_R, DELAY, NEXT, DONE, ERR.
REQ-015 SHALL stay in PWRUP PWRUP_CYC cycles, then enter FETCH with idx=0.
REQ-016 SHALL stay in FETCH 2 cycles, driving tbl_idx=idx, and register tbl_word in the second cycle.
REQ-017 SHALL, for dly_flag=1, enter DELAY for data*DLY_UNIT cycles (data=0: straight to NEXT) without issuing I2C; counter width fits (2**REG_DW-1)*DLY_UNIT.
REQ-018 SHALL, for dly_flag=0, pulse i2c_exec one cycle in WRITE with i2c_rh_wl=0, then hold i2c_addr/i2c_wdata stable in WAIT_W until i2c_done.
REQ-019 SHALL treat i2c_done with i2c_ack=0 as success and go to NEXT (or READ, see REQ-030).
REQ-020 SHALL treat i2c_ack=1 at i2c_done as failure: retry_cnt+1; reissue WRITE if retry_cnt<MAX_RETRY, else ERR.
REQ-021 SHALL clear retry_cnt on entering FETCH.
REQ-022 SHALL, in NEXT, go to DONE if idx==REG_NUM-1, else increment idx and go to FETCH.
REQ-023 SHALL assert i2c_exec exactly 3 cycles after the cycle in which a successful i2c_done is sampled, when the next entry is a write.
REQ-024 SHALL ignore i2c_done outside WAIT_W/WAIT_R and never pulse i2c_exec while in WAIT_W/WAIT_R.
REQ-025 SHALL hold cfg_done=1 in DONE; cfg_err=1 and err_idx=idx in ERR; cfg_busy=1 in all other states.
REQ-026 SHALL, on cfg_start in DONE or ERR, clear cfg_done/cfg_err and enter FETCH with idx=0, skipping PWRUP; cfg_start is ignored while cfg_busy=1.
REQ-027 SHALL support REG_NUM=1 (DONE after the single entry).

Reset
REQ-028 SHALL, on rst_n low at any time including mid-transfer, enter PWRUP and drive i2c_exec=0, i2c_rh_wl=0, i2c_addr=0, i2c_wdata=0, tbl_idx=0, cfg_busy=1, cfg_done=0, cfg_err=0, err_idx=0, and clear all counters.

Configuration
REQ-029 SHALL provide macro I2C_CFG_READBACK_EN.
REQ-030 SHALL, with I2C_CFG_READBACK_EN defined, after a successful write enter READ (i2c_exec pulse, i2c_rh_wl=1, same addr) then WAIT_R; on i2c_done with ack=0 and i2c_rdata==i2c_wdata go to NEXT, otherwise count one failure per REQ-020 and retry from WRITE.
REQ-031 SHALL, without the macro, omit READ/WAIT_R, tie i2c_rh_wl to 0 and leave i2c_rdata unused.

Verification
REQ-032 Reset release, PWRUP_CYC=255, ROM entry0={0,8'h00,8'h80} -> first i2c_exec 257 cycles after release (255 PWRUP + 2 FETCH), addr=8'h00, wdata=8'h80.
REQ-033 29 write entries, each i2c_done ack=0 after 50 cycles -> exactly 29 exec pulses, idx 0..28 in order, cfg_done=1, cfg_busy=0.
REQ-034 Entry2={1,x,8'd8}, DLY_UNIT=1000 -> no I2C for 8000 cycles between entry1 done and entry3 exec.
REQ-035 Entry5 NACKed 3 times, MAX_RETRY=3 -> 3 exec pulses at entry5, cfg_err=1, err_idx=5, no further exec; then cfg_start -> restart at idx 0 with no PWRUP wait.
REQ-036 READBACK_EN, entry4 write 8'hF3, first readback 8'hF0 then 8'hF3 -> write/read/write/read at addr 8'h02, proceeds to entry5.
REQ-037 rst_n low during WAIT_W of entry10 -> outputs at reset values; sequence restarts from PWRUP and idx 0.

Source files
------------

// File: rtl/i2c_cfg_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : i2c_cfg_seq                                                     |
// | Purpose  : Walks a register table in ROM and issues I2C writes or delays.  |
// |            Define I2C_CFG_READBACK_EN to read back and verify each write.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module i2c_cfg_seq #(
    parameter int REG_NUM   = 29,
    parameter int IDX_W     = 6,
    parameter int REG_AW    = 8,
    parameter int REG_DW    = 8,
    parameter int PWRUP_CYC = 255,
    parameter int DLY_UNIT  = 1000,
    parameter int MAX_RETRY = 3,
    localparam int TW       = 1 + REG_AW + REG_DW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    output logic [IDX_W-1:0]  tbl_idx,
    input  logic [TW-1:0]     tbl_word,
    output logic              i2c_exec,
    output logic              i2c_rh_wl,
    output logic [REG_AW-1:0] i2c_addr,
    output logic [REG_DW-1:0] i2c_wdata,
    input  logic              i2c_done,
    input  logic              i2c_ack,
    input  logic [REG_DW-1:0] i2c_rdata,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_err,
    output logic [IDX_W-1:0]  err_idx
);

    localparam int c_DLY_MAX = ((2 ** REG_DW) - 1) * DLY_UNIT;
    localparam int c_CNT_MAX = (c_DLY_MAX > PWRUP_CYC) ? c_DLY_MAX : PWRUP_CYC;
    localparam int c_CW      = $clog2(c_CNT_MAX + 1);
    localparam int c_RW      = $clog2(MAX_RETRY + 1);

    localparam logic [c_CW-1:0]  c_PWRUP_LAST = c_CW'(PWRUP_CYC - 1);
    localparam logic [IDX_W-1:0] c_LAST_IDX   = IDX_W'(REG_NUM - 1);
    localparam logic [c_RW-1:0]  c_RETRY_LIM  = c_RW'(MAX_RETRY);

    localparam logic [3:0] c_PWRUP  = 4'd0;
    localparam logic [3:0] c_FETCH  = 4'd1;
    localparam logic [3:0] c_WRITE  = 4'd2;
    localparam logic [3:0] c_WAIT_W = 4'd3;
    localparam logic [3:0] c_DELAY  = 4'd6;
    localparam logic [3:0] c_NEXT   = 4'd7;
    localparam logic [3:0] c_DONE   = 4'd8;
    localparam logic [3:0] c_ERR    = 4'd9;
`ifdef I2C_CFG_READBACK_EN
    localparam logic [3:0] c_READ   = 4'd4;
    localparam logic [3:0] c_WAIT_R = 4'd5;
`endif

    logic [3:0]        r_state, w_state_nxt;
    logic [IDX_W-1:0]  r_idx, w_idx_nxt;
    logic [c_CW-1:0]   r_cnt, w_cnt_nxt;
    logic              r_fph, w_fph_nxt;
    logic [c_RW-1:0]   r_retry, w_retry_nxt;
    logic [REG_AW-1:0] r_addr, w_addr_nxt;
    logic [REG_DW-1:0] r_wdata, w_wdata_nxt;

    logic              w_tw_dly;
    logic [REG_AW-1:0] w_tw_addr;
    logic [REG_DW-1:0] w_tw_data;
    logic [c_CW-1:0]   w_dly_cyc;
    logic [c_RW-1:0]   w_retry_inc;
    logic              w_last;

    assign w_tw_dly    = tbl_word[TW-1];
    assign w_tw_addr   = tbl_word[REG_AW+REG_DW-1:REG_DW];
    assign w_tw_data   = tbl_word[REG_DW-1:0];
    assign w_dly_cyc   = c_CW'(w_tw_data) * c_CW'(DLY_UNIT);
    assign w_retry_inc = r_retry + 1'b1;
    assign w_last      = (r_idx == c_LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_PWRUP;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_fph   <= 1'b0;
            r_retry <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_fph   <= w_fph_nxt;
            r_retry <= w_retry_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
        end
    end

    // A successful transfer takes the NEXT decision in the same cycle, so the
    // following write issues 3 cycles after i2c_done (2 FETCH + WRITE).
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_fph_nxt   = r_fph;
        w_retry_nxt = r_retry;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        case (r_state)
            c_PWRUP: begin
                if (r_cnt == c_PWRUP_LAST) begin
                    w_state_nxt = c_FETCH;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_retry_nxt = '0;
                    w_fph_nxt   = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_FETCH: begin
                if (!r_fph) begin
                    w_fph_nxt = 1'b1;
                end else begin
                    w_fph_nxt = 1'b0;
                    if (w_tw_dly) begin
                        if (w_tw_data == '0) begin
                            w_state_nxt = c_NEXT;
                        end else begin
                            w_state_nxt = c_DELAY;
                            w_cnt_nxt   = w_dly_cyc - 1'b1;
                        end
                    end else begin
                        w_state_nxt = c_WRITE;
                        w_addr_nxt  = w_tw_addr;
                        w_wdata_nxt = w_tw_data;
                    end
                end
            end
            c_WRITE: w_state_nxt = c_WAIT_W;
            c_WAIT_W: begin
                if (i2c_done) begin
                    if (!i2c_ack) begin
`ifdef I2C_CFG_READBACK_EN
                        w_state_nxt = c_READ;
`else
                        w_state_nxt = w_last ? c_DONE : c_FETCH;
                        w_idx_nxt   = w_last ? r_idx : r_idx + 1'b1;
                        w_retry_nxt = '0;
`endif
                    end else begin
                        w_retry_nxt = w_retry_inc;
                        w_state_nxt = (w_retry_inc < c_RETRY_LIM) ? c_WRITE : c_ERR;
                    end
                end
            end
`ifdef I2C_CFG_READBACK_EN
            c_READ: w_state_nxt = c_WAIT_R;
            c_WAIT_R: begin
                if (i2c_done) begin
                    if (!i2c_ack && (i2c_rdata == r_wdata)) begin
                        w_state_nxt = w_last ? c_DONE : c_FETCH;
                        w_idx_nxt   = w_last ? r_idx : r_idx + 1'b1;
                        w_retry_nxt = '0;
                    end else begin
                        w_retry_nxt = w_retry_inc;
                        w_state_nxt = (w_retry_inc < c_RETRY_LIM) ? c_WRITE : c_ERR;
                    end
                end
            end
`endif
            c_DELAY: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_NEXT;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            c_NEXT: begin
                w_state_nxt = w_last ? c_DONE : c_FETCH;
                w_idx_nxt   = w_last ? r_idx : r_idx + 1'b1;
                w_retry_nxt = '0;
            end
            c_DONE, c_ERR: begin
                if (cfg_start) begin
                    w_state_nxt = c_FETCH;
                    w_idx_nxt   = '0;
                    w_retry_nxt = '0;
                    w_fph_nxt   = 1'b0;
                end
            end
            default: w_state_nxt = c_PWRUP;
        endcase
    end

    assign tbl_idx   = r_idx;
    assign i2c_addr  = r_addr;
    assign i2c_wdata = r_wdata;
    assign cfg_done  = (r_state == c_DONE);
    assign cfg_err   = (r_state == c_ERR);
    assign cfg_busy  = !(cfg_done || cfg_err);
    assign err_idx   = cfg_err ? r_idx : '0;

`ifdef I2C_CFG_READBACK_EN
    assign i2c_exec  = (r_state == c_WRITE) || (r_state == c_READ);
    assign i2c_rh_wl = (r_state == c_READ) || (r_state == c_WAIT_R);
`else
    logic w_unused_rdata;
    assign w_unused_rdata = ^i2c_rdata;
    assign i2c_exec  = (r_state == c_WRITE);
    assign i2c_rh_wl = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2c_cfg_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_i2c_cfg_seq                                                  |
// | Purpose  : Directed bench for i2c_cfg_seq with ROM and I2C slave models.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_i2c_cfg_seq;

    localparam int c_NUM = 29;
    localparam int c_IW  = 6;
    localparam int c_TW  = 17;
    localparam int c_LAT = 50;
`ifdef I2C_CFG_READBACK_EN
    localparam int c_PER = 2;
`else
    localparam int c_PER = 1;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_start = 1'b0;
    logic [c_IW-1:0]   tbl_idx;
    logic [c_TW-1:0]   tbl_word = '0;
    logic              i2c_exec, i2c_rh_wl;
    logic [7:0]        i2c_addr, i2c_wdata;
    logic              i2c_done = 1'b0;
    logic              i2c_ack = 1'b0;
    logic [7:0]        i2c_rdata = '0;
    logic              cfg_busy, cfg_done, cfg_err;
    logic [c_IW-1:0]   err_idx;

    i2c_cfg_seq dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start),
        .tbl_idx(tbl_idx), .tbl_word(tbl_word),
        .i2c_exec(i2c_exec), .i2c_rh_wl(i2c_rh_wl), .i2c_addr(i2c_addr),
        .i2c_wdata(i2c_wdata), .i2c_done(i2c_done), .i2c_ack(i2c_ack),
        .i2c_rdata(i2c_rdata), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
        .cfg_err(cfg_err), .err_idx(err_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [c_TW-1:0] rom [64];
    always @(posedge clk) tbl_word <= rom[tbl_idx];

    int n_cmp = 0;
    int n_fail = 0;

    // Slave model and transfer log.
    int              n_exec = 0;
    int              viol = 0;
    int              pend = 0;
    logic            cur_rw = 1'b0;
    int              cur_idx = 0;
    logic [7:0]      last_w = '0;
    int              nack_idx = -1;
    int              nack_left = 0;
    int              bad_idx = -1;
    int              bad_left = 0;
    logic [7:0]      bad_val = '0;
    int              log_idx [256];
    logic            log_rw [256];
    logic [7:0]      log_addr [256];
    logic [7:0]      log_wd [256];
    int              log_cyc [256];
    int              done_cyc [64];

    always @(negedge clk) begin
        i2c_done = 1'b0;
        i2c_ack  = 1'b0;
        if (!rst_n) begin
            pend = 0;
        end else if (i2c_exec === 1'b1) begin
            if (pend > 0) viol++;
            if (n_exec < 256) begin
                log_idx[n_exec]  = int'(tbl_idx);
                log_rw[n_exec]   = i2c_rh_wl;
                log_addr[n_exec] = i2c_addr;
                log_wd[n_exec]   = i2c_wdata;
                log_cyc[n_exec]  = cyc;
            end
            n_exec++;
            pend    = c_LAT;
            cur_rw  = i2c_rh_wl;
            cur_idx = int'(tbl_idx);
            if (!i2c_rh_wl) last_w = i2c_wdata;
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                i2c_done = 1'b1;
                if (!cur_rw && cur_idx == nack_idx && nack_left > 0) begin
                    i2c_ack = 1'b1;
                    nack_left--;
                end
                if (cur_rw && cur_idx == bad_idx && bad_left > 0) begin
                    i2c_rdata = bad_val;
                    bad_left--;
                end else begin
                    i2c_rdata = last_w;
                end
                done_cyc[cur_idx] = cyc;
            end
        end
    end

    function automatic logic [32:0] outs();
        return {i2c_exec, i2c_rh_wl, i2c_addr, i2c_wdata, tbl_idx,
                cfg_busy, cfg_done, cfg_err, err_idx};
    endfunction

    task automatic load_rom_a();
        for (int i = 0; i < 64; i++) rom[i] = {1'b0, 8'(i), 8'(128 + i * 5)};
    endtask

    task automatic pulse_start(output int s);
        @(negedge clk);
        cfg_start = 1'b1;
        s = cyc;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cfg_done || cfg_err) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        load_rom_a();
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (outs() !== 33'h100) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want %h", outs(), 33'h100);
        end
    endtask

    task automatic test_pwrup_full();
        int r, bad, sp;
        bit ok;
        n_exec = 0;
        @(negedge clk);
        rst_n = 1'b1;
        r = cyc;
        wait_end(20000, ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL full_timeout: got %0d want 1", ok); end
        n_cmp++;
        if (log_cyc[0] - r !== 257) begin
            n_fail++; $display("FAIL first_exec_latency: got %0d want 257", log_cyc[0] - r);
        end
        n_cmp++;
        if ({log_addr[0], log_wd[0]} !== 16'h0080) begin
            n_fail++; $display("FAIL first_addr_data: got %h want 0080", {log_addr[0], log_wd[0]});
        end
        n_cmp++;
        if (n_exec !== c_NUM * c_PER) begin
            n_fail++; $display("FAIL full_exec_count: got %0d want %0d", n_exec, c_NUM * c_PER);
        end
        bad = 0;
        for (int j = 0; j < n_exec && j < 256; j++) begin
            if (log_idx[j] != j / c_PER || log_rw[j] !== 1'(j % c_PER) ||
                log_addr[j] !== 8'(j / c_PER) || log_wd[j] !== 8'(128 + (j / c_PER) * 5)) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin n_fail++; $display("FAIL full_order: got %0d bad entries want 0", bad); end
        sp = 0;
        for (int k = 0; k < c_NUM - 1; k++) if (log_cyc[(k + 1) * c_PER] - done_cyc[k] != 3) sp++;
        n_cmp++;
        if (sp !== 0) begin n_fail++; $display("FAIL done_to_exec_3: got %0d bad gaps want 0", sp); end
        n_cmp++;
        if (viol !== 0) begin n_fail++; $display("FAIL exec_in_wait: got %0d want 0", viol); end
        n_cmp++;
        if ({cfg_done, cfg_busy, cfg_err} !== 3'b100) begin
            n_fail++; $display("FAIL full_status: got %b want 100", {cfg_done, cfg_busy, cfg_err});
        end
    endtask

    task automatic test_delay();
        int s;
        bit ok;
        rom[2] = {1'b1, 8'hAA, 8'd8};
        n_exec = 0;
        pulse_start(s);
        wait_end(30000, ok);
        n_cmp++;
        if (ok !== 1'b1 || cfg_done !== 1'b1) begin
            n_fail++; $display("FAIL delay_done: got %0d/%b want 1/1", ok, cfg_done);
        end
        n_cmp++;
        if (log_cyc[0] - s !== 3) begin
            n_fail++; $display("FAIL restart_latency: got %0d want 3", log_cyc[0] - s);
        end
        n_cmp++;
        if (n_exec !== (c_NUM - 1) * c_PER) begin
            n_fail++; $display("FAIL delay_exec_count: got %0d want %0d", n_exec, (c_NUM - 1) * c_PER);
        end
        n_cmp++;
        if (log_idx[2 * c_PER] !== 3 || log_cyc[2 * c_PER] - done_cyc[1] !== 8006) begin
            n_fail++;
            $display("FAIL delay_gap: got idx %0d gap %0d want idx 3 gap 8006",
                     log_idx[2 * c_PER], log_cyc[2 * c_PER] - done_cyc[1]);
        end
        load_rom_a();
    endtask

    task automatic test_nack();
        int s, n5, nsave;
        bit ok;
        nack_idx = 5;
        nack_left = 1000;
        n_exec = 0;
        pulse_start(s);
        wait_end(5000, ok);
        n_cmp++;
        if ({ok, cfg_err, cfg_done, cfg_busy} !== 4'b1100) begin
            n_fail++; $display("FAIL nack_status: got %b want 1100", {ok, cfg_err, cfg_done, cfg_busy});
        end
        n_cmp++;
        if (err_idx !== 6'd5) begin n_fail++; $display("FAIL nack_err_idx: got %0d want 5", err_idx); end
        n5 = 0;
        for (int j = 0; j < n_exec && j < 256; j++) if (log_idx[j] == 5) n5++;
        n_cmp++;
        if (n5 !== 3 || n_exec !== 5 * c_PER + 3) begin
            n_fail++; $display("FAIL nack_attempts: got %0d/%0d want 3/%0d", n5, n_exec, 5 * c_PER + 3);
        end
        nsave = n_exec;
        repeat (300) @(negedge clk);
        n_cmp++;
        if (n_exec !== nsave) begin n_fail++; $display("FAIL exec_after_err: got %0d want %0d", n_exec, nsave); end
        nack_left = 0;
    endtask

    task automatic test_restart();
        int s, d, bad;
        bit ok;
        n_exec = 0;
        pulse_start(s);
        for (int i = 0; i < 2000 && n_exec < 3; i++) @(negedge clk);
        pulse_start(d);
        wait_end(20000, ok);
        n_cmp++;
        if (log_cyc[0] - s !== 3 || log_idx[0] !== 0) begin
            n_fail++; $display("FAIL err_restart: got lat %0d idx %0d want 3 0", log_cyc[0] - s, log_idx[0]);
        end
        bad = 0;
        for (int j = 0; j < n_exec && j < 256; j++) if (log_idx[j] != j / c_PER) bad++;
        n_cmp++;
        if (!ok || cfg_done !== 1'b1 || n_exec !== c_NUM * c_PER || bad !== 0) begin
            n_fail++; $display("FAIL busy_start_ignored: got n %0d bad %0d done %b want %0d 0 1",
                               n_exec, bad, cfg_done, c_NUM * c_PER);
        end
    endtask

`ifdef I2C_CFG_READBACK_EN
    task automatic test_readback();
        int s, f;
        bit ok;
        rom[4] = {1'b0, 8'h02, 8'hF3};
        bad_idx = 4;
        bad_left = 1;
        bad_val = 8'hF0;
        n_exec = 0;
        pulse_start(s);
        wait_end(20000, ok);
        f = 8;
        n_cmp++;
        if (!ok || cfg_done !== 1'b1 || n_exec !== c_NUM * 2 + 2) begin
            n_fail++; $display("FAIL rb_done: got n %0d done %b want %0d 1", n_exec, cfg_done, c_NUM * 2 + 2);
        end
        n_cmp++;
        if ({log_rw[f], log_rw[f+1], log_rw[f+2], log_rw[f+3]} !== 4'b0101 ||
            {log_addr[f], log_addr[f+1], log_addr[f+2], log_addr[f+3]} !== 32'h02020202 ||
            log_wd[f] !== 8'hF3 || log_idx[f+3] !== 4 || log_idx[f+4] !== 5) begin
            n_fail++; $display("FAIL rb_sequence: got rw %b addr %h idx_after %0d want 0101 02020202 5",
                               {log_rw[f], log_rw[f+1], log_rw[f+2], log_rw[f+3]},
                               {log_addr[f], log_addr[f+1], log_addr[f+2], log_addr[f+3]}, log_idx[f+4]);
        end
        bad_idx = -1;
        load_rom_a();
    endtask
`endif

    task automatic test_mid_reset();
        int s, r;
        bit ok, hit;
        n_exec = 0;
        pulse_start(s);
        hit = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (n_exec > 0 && log_idx[n_exec - 1] == 10 && pend > 0 && pend < c_LAT - 3) begin
                hit = 1'b1;
                break;
            end
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (!hit || outs() !== 33'h100) begin
            n_fail++; $display("FAIL midreset_outputs: got %h hit %b want %h 1", outs(), hit, 33'h100);
        end
        repeat (3) @(negedge clk);
        n_exec = 0;
        rst_n = 1'b1;
        r = cyc;
        for (int i = 0; i < 400 && n_exec == 0; i++) @(negedge clk);
        n_cmp++;
        if (n_exec == 0 || log_cyc[0] - r !== 257 || log_idx[0] !== 0) begin
            n_fail++; $display("FAIL midreset_restart: got n %0d lat %0d idx %0d want >0 257 0",
                               n_exec, log_cyc[0] - r, log_idx[0]);
        end
        wait_end(20000, ok);
        n_cmp++;
        if (!ok || cfg_done !== 1'b1 || n_exec !== c_NUM * c_PER) begin
            n_fail++; $display("FAIL midreset_complete: got n %0d done %b want %0d 1", n_exec, cfg_done, c_NUM * c_PER);
        end
    endtask

    initial begin
        test_reset();
        test_pwrup_full();
        test_delay();
        test_nack();
        test_restart();
`ifdef I2C_CFG_READBACK_EN
        test_readback();
`endif
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
